// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// the architectural zero-register index.
package hazard_ctrl_pkg;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_MEMWAIT = 1'b1
   } state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones instead of
// wrapping; Clr has priority.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         Clk,
   input  logic         Clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (inc && (q_q != '1)) begin
         q_d = q_q + 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Clr) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch/jump flushes and a
// whole-pipe freeze while data memory is busy, with timeout and perf counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int TO_W        = 8,
   parameter int MEM_TIMEOUT = 200
) (
   input  logic             Clk,
   input  logic             Clr,
   input  logic [4:0]       ID_Rs,
   input  logic [4:0]       ID_Rt,
   input  logic             ID_UseRt,
   input  logic             EX_MemtoReg,
   input  logic [4:0]       EX_Rt,
   input  logic             MEM_PCSrc,
   input  logic             MEM_Req,
   input  logic             dmem_ready,
   output logic             PC_Wr,
   output logic             IF_ID_Wr,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Bubble,
   output logic             ID_EX_Flush,
   output logic             Pipe_Hold,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] wait_cnt
);

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);
   localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

   state_t          state_q, state_d;
   logic [TO_W-1:0] to_q, to_d;
   logic            mem_err_q, mem_err_d;

   logic lu;
   logic mw;
   logic hold;
   logic stall_inc;
   logic flush_inc;
   logic wait_inc;

   assign lu = EX_MemtoReg && (EX_Rt != REG_ZERO) &&
               ((EX_Rt == ID_Rs) || (ID_UseRt && (EX_Rt == ID_Rt)));
   assign mw = MEM_Req && !dmem_ready;

   // In MEMWAIT the freeze lasts until ready, even if the request line has dropped.
   assign hold = (state_q == ST_MEMWAIT) ? !dmem_ready : mw;

   always_ff @(posedge Clk) begin
      if (Clr) begin
         state_q   <= ST_RUN;
         to_q      <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         to_q      <= to_d;
         mem_err_q <= mem_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      to_d      = to_q;
      mem_err_d = mem_err_q;
      case (state_q)
         ST_RUN: begin
            if (mw) begin
               state_d = ST_MEMWAIT;
               to_d    = TO_ONE;
            end
         end
         ST_MEMWAIT: begin
            if (dmem_ready) begin
               state_d = ST_RUN;
               to_d    = '0;
            end else if (to_q == TO_LIMIT) begin
               // Abort: hold is still asserted this cycle, drops next cycle.
               state_d   = ST_RUN;
               to_d      = '0;
               mem_err_d = 1'b1;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_RUN;
            to_d    = '0;
         end
      endcase
   end

   always_comb begin
      PC_Wr        = 1'b1;
      IF_ID_Wr     = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Bubble = 1'b0;
      ID_EX_Flush  = 1'b0;
      Pipe_Hold    = 1'b0;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      wait_inc     = 1'b0;
      if (!Clr) begin
         if (hold) begin
            Pipe_Hold = 1'b1;
            PC_Wr     = 1'b0;
            IF_ID_Wr  = 1'b0;
            wait_inc  = 1'b1;
         end else if (MEM_PCSrc) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
            flush_inc   = 1'b1;
         end else if (lu) begin
            PC_Wr        = 1'b0;
            IF_ID_Wr     = 1'b0;
            ID_EX_Bubble = 1'b1;
            stall_inc    = 1'b1;
         end
      end
   end

   assign mem_err = mem_err_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .Clk (Clk),
      .Clr (Clr),
      .inc (stall_inc),
      .q   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .Clk (Clk),
      .Clr (Clr),
      .inc (flush_inc),
      .q   (flush_cnt)
   );

   sat_counter #(.W(CNT_W)) u_wait_cnt (
      .Clk (Clk),
      .Clr (Clr),
      .inc (wait_inc),
      .q   (wait_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with small counters and a short memory timeout.
module tb_hazard_ctrl;

   localparam int CNT_W = 4;

   // Packed view of {PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Bubble, ID_EX_Flush, Pipe_Hold}
   localparam logic [5:0] O_NORM  = 6'b110000;
   localparam logic [5:0] O_STALL = 6'b000100;
   localparam logic [5:0] O_FLUSH = 6'b111010;
   localparam logic [5:0] O_HOLD  = 6'b000001;

   logic             Clk;
   logic             Clr;
   logic [4:0]       ID_Rs;
   logic [4:0]       ID_Rt;
   logic             ID_UseRt;
   logic             EX_MemtoReg;
   logic [4:0]       EX_Rt;
   logic             MEM_PCSrc;
   logic             MEM_Req;
   logic             dmem_ready;
   logic             PC_Wr;
   logic             IF_ID_Wr;
   logic             IF_ID_Flush;
   logic             ID_EX_Bubble;
   logic             ID_EX_Flush;
   logic             Pipe_Hold;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] wait_cnt;

   int checks = 0;
   int errors = 0;

   hazard_ctrl #(
      .CNT_W       (CNT_W),
      .TO_W        (8),
      .MEM_TIMEOUT (4)
   ) dut (
      .Clk          (Clk),
      .Clr          (Clr),
      .ID_Rs        (ID_Rs),
      .ID_Rt        (ID_Rt),
      .ID_UseRt     (ID_UseRt),
      .EX_MemtoReg  (EX_MemtoReg),
      .EX_Rt        (EX_Rt),
      .MEM_PCSrc    (MEM_PCSrc),
      .MEM_Req      (MEM_Req),
      .dmem_ready   (dmem_ready),
      .PC_Wr        (PC_Wr),
      .IF_ID_Wr     (IF_ID_Wr),
      .IF_ID_Flush  (IF_ID_Flush),
      .ID_EX_Bubble (ID_EX_Bubble),
      .ID_EX_Flush  (ID_EX_Flush),
      .Pipe_Hold    (Pipe_Hold),
      .mem_err      (mem_err),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt),
      .wait_cnt     (wait_cnt)
   );

   // Clock and reset
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Driver tasks
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input logic clr, input logic [4:0] rs, input logic [4:0] rt,
                        input logic use_rt, input logic ld, input logic [4:0] ex_rt,
                        input logic pcsrc, input logic req, input logic rdy);
      Clr         = clr;
      ID_Rs       = rs;
      ID_Rt       = rt;
      ID_UseRt    = use_rt;
      EX_MemtoReg = ld;
      EX_Rt       = ex_rt;
      MEM_PCSrc   = pcsrc;
      MEM_Req     = req;
      dmem_ready  = rdy;
   endtask

   // Checkers
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [5:0] exp);
      #1;
      chk(tag, {26'd0, PC_Wr, IF_ID_Wr, IF_ID_Flush, ID_EX_Bubble, ID_EX_Flush, Pipe_Hold},
          {26'd0, exp});
   endtask

   task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] s,
                          input logic [CNT_W-1:0] f, input logic [CNT_W-1:0] w);
      chk({tag, "_stall"}, {28'd0, stall_cnt}, {28'd0, s});
      chk({tag, "_flush"}, {28'd0, flush_cnt}, {28'd0, f});
      chk({tag, "_wait"},  {28'd0, wait_cnt},  {28'd0, w});
   endtask

   // Directed sequence
   initial begin
      // Reset, with a load-use pattern present to show Clr wins
      drive(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
      chk_out("clr_out", O_NORM);
      tick();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk_out("rst_out", O_NORM);
      chk("rst_err", {31'd0, mem_err}, 32'd0);
      chk_cnt("rst", 4'd0, 4'd0, 4'd0);

      // lw $5 in EX, ID reads $5 through Rs: exactly one bubble
      drive(1'b0, 5'd5, 5'd3, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      chk_out("lu_rs", O_STALL);
      tick();
      chk_cnt("lu_rs", 4'd1, 4'd0, 4'd0);
      drive(1'b0, 5'd5, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk_out("lu_clear", O_NORM);
      tick();

      // Load to $0 never stalls; Rt match ignored unless ID reads Rt
      drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      chk_out("lu_r0", O_NORM);
      drive(1'b0, 5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
      chk_out("lu_rt_unused", O_NORM);
      drive(1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
      chk_out("lu_rt_used", O_STALL);
      tick();
      chk_cnt("lu_rt", 4'd2, 4'd0, 4'd0);

      // Taken branch beats load-use
      drive(1'b0, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
      chk_out("flush_over_lu", O_FLUSH);
      tick();
      chk_cnt("flush", 4'd2, 4'd1, 4'd0);

      // Memory wait: ready low 3 cycles, branch ignored while holding
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
      chk_out("mw_enter", O_HOLD);
      tick();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      chk_out("mw_hold2", O_HOLD);
      tick();
      chk_out("mw_hold3", O_HOLD);
      tick();
      chk_cnt("mw_hold", 4'd2, 4'd1, 4'd3);
      // Release cycle evaluates normally: a load-use here stalls
      drive(1'b0, 5'd9, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1);
      chk_out("mw_release", O_STALL);
      tick();
      chk_cnt("mw_release", 4'd3, 4'd1, 4'd3);
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk_out("mw_back_run", O_NORM);
      tick();

      // Timeout: entry cycle plus 4 MEMWAIT cycles of hold, then abort
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk_out($sformatf("to_hold%0d", i), O_HOLD);
         tick();
         chk($sformatf("to_err%0d", i), {31'd0, mem_err}, (i == 4) ? 32'd1 : 32'd0);
      end
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk_out("to_run", O_NORM);
      chk_cnt("to", 4'd3, 4'd1, 4'd8);
      tick();
      chk("to_sticky", {31'd0, mem_err}, 32'd1);

      // Clr while in MEMWAIT
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      chk_out("clr_mw_out", O_NORM);
      tick();
      drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      chk_out("clr_mw_run", O_NORM);
      chk("clr_mw_err", {31'd0, mem_err}, 32'd0);
      chk_cnt("clr_mw", 4'd0, 4'd0, 4'd0);

      // Stall counter saturates at 4'hF
      drive(1'b0, 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 18; i++) begin
         tick();
         chk($sformatf("sat%0d", i), {28'd0, stall_cnt}, (i > 15) ? 32'd15 : 32'(i));
      end

      // Final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage MIPS core: the block that sequences the ID/EX register's `bubble` and `MEM_PCSrc` flush inputs and the upstream write enables.
- Detects load-use hazards, propagates branch/jump flushes, and freezes the whole pipeline during multi-cycle data-memory accesses via a ready handshake with timeout.
- Keeps saturating stall, flush and memory-wait performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.
- TO_W, 8, width of the memory-wait timeout counter.
- MEM_TIMEOUT, 200, maximum wait cycles for dmem_ready before abort (must be < 2**TO_W).

Ports:
- Clk  in  1  clock; state updates on posedge, outputs settle before the pipeline-register negedge.
- Clr  in  1  synchronous active-high reset.
- ID_Rs  in  5  Rs field of the instruction in ID.
- ID_Rt  in  5  Rt field of the instruction in ID.
- ID_UseRt  in  1  ID instruction reads Rt (R-type, branch, store).
- EX_MemtoReg  in  1  instruction in EX is a load.
- EX_Rt  in  5  destination of the load in EX.
- MEM_PCSrc  in  1  branch/jump taken, resolved in MEM.
- MEM_Req  in  1  MEM stage performs a data-memory access (load or store).
- dmem_ready  in  1  data memory completes the access this cycle.
- PC_Wr  out  1  PC write enable.
- IF_ID_Wr  out  1  IF/ID write enable.
- IF_ID_Flush  out  1  clear IF/ID to NOP.
- ID_EX_Bubble  out  1  drives ID/EX `bubble`.
- ID_EX_Flush  out  1  drives ID/EX `MEM_PCSrc` input.
- Pipe_Hold  out  1  freeze EX/MEM and MEM/WB (hold contents).
- mem_err  out  1  sticky: memory access timed out.
- stall_cnt  out  CNT_W  load-use bubbles inserted.
- flush_cnt  out  CNT_W  flushes issued.
- wait_cnt  out  CNT_W  cycles spent in MEMWAIT.

Behaviour:
- Reset: Clr sampled on posedge. Next state RUN; mem_err=0; all counters=0; timeout counter=0.
- Reset output values: PC_Wr=1, IF_ID_Wr=1, all flush/bubble/hold signals=0.
- FSM has two states, RUN and MEMWAIT.
- Hazard definitions:
  - lu = EX_MemtoReg && EX_Rt!=0 && (EX_Rt==ID_Rs || (ID_UseRt && EX_Rt==ID_Rt)).
  - mw = MEM_Req && !dmem_ready.
- Output priority within a cycle: MEMWAIT/mw > MEM_PCSrc > lu.
- RUN, mw=1:
  - Pipe_Hold=1, PC_Wr=0, IF_ID_Wr=0, ID_EX_Bubble=0, ID_EX_Flush=0.
  - Any MEM_PCSrc and lu are ignored this cycle (re-evaluated after release).
  - Go to MEMWAIT; timeout counter <=1; wait_cnt+1.
- RUN, mw=0, MEM_PCSrc=1:
  - IF_ID_Flush=1, ID_EX_Flush=1, PC_Wr=1, IF_ID_Wr=1, ID_EX_Bubble=0.
  - flush_cnt+1. lu is suppressed, since the ID instruction is being discarded.
- RUN, mw=0, MEM_PCSrc=0, lu=1: PC_Wr=0, IF_ID_Wr=0, ID_EX_Bubble=1; stall_cnt+1.
  - Exactly one bubble per load: next cycle the EX instruction is the bubble (EX_MemtoReg=0), so lu clears.
- RUN, no hazard: PC_Wr=1, IF_ID_Wr=1, all others 0.
- MEMWAIT: outputs as RUN/mw=1; wait_cnt+1 per cycle.
  - dmem_ready=1: release this cycle (Pipe_Hold=0, normal RUN priority evaluation applies); next state RUN.
  - Timeout counter reaches MEM_TIMEOUT with ready=0: mem_err<=1 (sticky until Clr); next state RUN; hold drops the following cycle.
- Counters saturate at all-ones and do not wrap.
- Clr mid-MEMWAIT: returns to RUN next edge and clears mem_err.
- Clr has priority over all inputs.

Decomposition:
- Shared package holds the state encoding (RUN=1'b0, MEMWAIT=1'b1) and the register-zero constant 5'd0.
- One natural sub-module: sat_counter (parameter W; inputs Clk, Clr, inc; output q). Instantiate it three times.

Test Plan:
- lw $5 in EX (EX_MemtoReg=1, EX_Rt=5), ID add with ID_Rs=5 -> one cycle PC_Wr=0, IF_ID_Wr=0, ID_EX_Bubble=1; next cycle clear; stall_cnt=1.
- Load with EX_Rt=0 and ID_Rs=0 -> no bubble. Load EX_Rt=7, ID_Rt=7, ID_UseRt=0 -> no bubble.
- MEM_PCSrc=1 together with lu=1 -> IF_ID_Flush=1, ID_EX_Flush=1, ID_EX_Bubble=0, PC_Wr=1; flush_cnt=1, stall_cnt unchanged.
- MEM_Req=1, dmem_ready low 3 cycles then high -> Pipe_Hold=1 for 3 cycles, released in the ready cycle; wait_cnt=3; state RUN.
- MEM_Req=1 with dmem_ready never high, MEM_TIMEOUT=4 -> mem_err=1 after 4 MEMWAIT cycles; return to RUN; Clr then clears mem_err and all counters to 0.
- Force stall_cnt to all-ones (CNT_W=4, 16 load-use events) -> stays 4'hF.
